// File: rtl/huffman_merge_ctrl.sv
// huffman_merge_ctrl
//   Sequencing stage around the six-entry sort-and-merge PE of the Huffman
//   code builder. Holds entry registers E1..E6, feeds them to the PE, writes
//   back the sorted/merged result for five iterations and builds each
//   symbol's codeword and length from the two smallest entries' masks.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   start                 build request, sampled only in IDLE
//   cnt_in[47:0]          symbol counts, symbol k at [8k-1:8k-8]
//   busy, done            busy in MERGE/DONE; done one-cycle pulse
//   code_flat[29:0]       codeword of symbol k at [5k-1:5k-5], bit0 = leaf side
//   len_flat[17:0]        code length of symbol k at [3k-1:3k-3]
//   pe_cnt1..6            entry registers to the PE
//   pe_cnt1_n..6_n        PE sorted outputs (5 = 2nd smallest, 6 = smallest)
//   pe_sum, pe_flag       PE merged count and mask

// Per-symbol codeword/length accumulator.
module huffman_sym_code #(
    parameter int CLEN_W = 5,
    parameter int LEN_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              upd,
    input  logic              hit1,
    input  logic              hit0,
    output logic [CLEN_W-1:0] code,
    output logic [LEN_W-1:0]  len
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code <= '0;
            len  <= '0;
        end else if (clr) begin
            code <= '0;
            len  <= '0;
        end else if (upd && (hit1 || hit0)) begin
            // Append one bit at the current length: smallest branch gets 1.
            for (int b = 0; b < CLEN_W; b++) begin
                if (len == LEN_W'(b))
                    code[b] <= hit1;
            end
            len <= len + 1'b1;
        end
    end
endmodule

module huffman_merge_ctrl #(
    parameter int NSYM   = 6,
    parameter int CLEN_W = 5,
    parameter int LEN_W  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*NSYM-1:0]      cnt_in,
    output logic                   busy,
    output logic                   done,
    output logic [CLEN_W*NSYM-1:0] code_flat,
    output logic [LEN_W*NSYM-1:0]  len_flat,
    output logic [14:0]            pe_cnt1,
    output logic [14:0]            pe_cnt2,
    output logic [14:0]            pe_cnt3,
    output logic [14:0]            pe_cnt4,
    output logic [14:0]            pe_cnt5,
    output logic [14:0]            pe_cnt6,
    input  logic [14:0]            pe_cnt1_n,
    input  logic [14:0]            pe_cnt2_n,
    input  logic [14:0]            pe_cnt3_n,
    input  logic [14:0]            pe_cnt4_n,
    input  logic [14:0]            pe_cnt5_n,
    input  logic [14:0]            pe_cnt6_n,
    input  logic [7:0]             pe_sum,
    input  logic [6:0]             pe_flag
);
    // Empty marker set plus all-ones: sorts above every real entry.
    localparam logic [14:0] EMPTY = 15'h7FFF;

    typedef enum logic [1:0] {S_IDLE, S_MERGE, S_DONE} state_t;

    state_t                 state, state_nx;
    logic [2:0]             mcnt;
    logic [NSYM-1:0][14:0]  ent;
    logic                   load, merge;

    // Only the mask bits of the two smallest outputs drive code building.
    logic unused_pe;
    assign unused_pe = ^{pe_cnt5_n[14:6], pe_cnt6_n[14:6]};

    assign load  = (state == S_IDLE) && start;
    assign merge = (state == S_MERGE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_MERGE;
            S_MERGE: if (mcnt == 3'd4) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Entry registers and merge counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent  <= {NSYM{EMPTY}};
            mcnt <= '0;
        end else if (load) begin
            for (int k = 0; k < NSYM; k++)
                ent[k] <= {cnt_in[8*k +: 8], 1'b0, 6'(6'b1 << k)};
            mcnt <= '0;
        end else if (merge) begin
            ent[0] <= pe_cnt1_n;
            ent[1] <= pe_cnt2_n;
            ent[2] <= pe_cnt3_n;
            ent[3] <= pe_cnt4_n;
            ent[4] <= {pe_sum, pe_flag};
            ent[5] <= EMPTY;
            mcnt   <= mcnt + 3'd1;
        end
    end

    assign pe_cnt1 = ent[0];
    assign pe_cnt2 = ent[1];
    assign pe_cnt3 = ent[2];
    assign pe_cnt4 = ent[3];
    assign pe_cnt5 = ent[4];
    assign pe_cnt6 = ent[5];

    for (genvar k = 0; k < NSYM; k++) begin : g_sym
        huffman_sym_code #(.CLEN_W(CLEN_W), .LEN_W(LEN_W)) u_sym (
            .clk  (clk),
            .rst_n(rst_n),
            .clr  (load),
            .upd  (merge),
            .hit1 (pe_cnt6_n[k]),
            .hit0 (pe_cnt5_n[k]),
            .code (code_flat[k*CLEN_W +: CLEN_W]),
            .len  (len_flat[k*LEN_W +: LEN_W])
        );
    end
endmodule

// File: tb/tb_huffman_merge_ctrl.sv
module tb_huffman_merge_ctrl;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [47:0] cnt_in = '0;
    logic        busy, done;
    logic [29:0] code_flat;
    logic [17:0] len_flat;
    logic [14:0] pe_cnt1, pe_cnt2, pe_cnt3, pe_cnt4, pe_cnt5, pe_cnt6;
    logic [14:0] pe_cnt1_n, pe_cnt2_n, pe_cnt3_n, pe_cnt4_n, pe_cnt5_n, pe_cnt6_n;
    logic [7:0]  pe_sum;
    logic [6:0]  pe_flag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    huffman_merge_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cnt_in(cnt_in),
        .busy(busy), .done(done), .code_flat(code_flat), .len_flat(len_flat),
        .pe_cnt1(pe_cnt1), .pe_cnt2(pe_cnt2), .pe_cnt3(pe_cnt3),
        .pe_cnt4(pe_cnt4), .pe_cnt5(pe_cnt5), .pe_cnt6(pe_cnt6),
        .pe_cnt1_n(pe_cnt1_n), .pe_cnt2_n(pe_cnt2_n), .pe_cnt3_n(pe_cnt3_n),
        .pe_cnt4_n(pe_cnt4_n), .pe_cnt5_n(pe_cnt5_n), .pe_cnt6_n(pe_cnt6_n),
        .pe_sum(pe_sum), .pe_flag(pe_flag)
    );

    // ---------------- PE stand-in: sort and merge ----------------
    logic [14:0] ein [6];
    logic [14:0] sv  [4];
    int s_lo, s_hi, sj;
    assign ein[0] = pe_cnt1;
    assign ein[1] = pe_cnt2;
    assign ein[2] = pe_cnt3;
    assign ein[3] = pe_cnt4;
    assign ein[4] = pe_cnt5;
    assign ein[5] = pe_cnt6;

    always_comb begin
        sv = '{default: '0};
        s_lo = 0;
        for (int i = 1; i < 6; i++) if (ein[i] < ein[s_lo]) s_lo = i;
        s_hi = (s_lo == 0) ? 1 : 0;
        for (int i = 0; i < 6; i++) if (i != s_lo && ein[i] < ein[s_hi]) s_hi = i;
        sj = 0;
        for (int i = 0; i < 6; i++) begin
            if (i != s_lo && i != s_hi && sj < 4) begin
                sv[sj] = ein[i];
                sj = sj + 1;
            end
        end
    end

    assign pe_cnt1_n = sv[0];
    assign pe_cnt2_n = sv[1];
    assign pe_cnt3_n = sv[2];
    assign pe_cnt4_n = sv[3];
    assign pe_cnt5_n = ein[s_hi];
    assign pe_cnt6_n = ein[s_lo];
    assign pe_sum    = ein[s_lo][14:7] + ein[s_hi][14:7];
    assign pe_flag   = {1'b0, ein[s_lo][5:0] | ein[s_hi][5:0]};

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] pk_cnt(int a, int b, int c, int d, int e, int f);
        return {8'(f), 8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction
    function automatic logic [17:0] pk_len(int a, int b, int c, int d, int e, int f);
        return {3'(f), 3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction
    function automatic logic [29:0] pk_code(int a, int b, int c, int d, int e, int f);
        return {5'(f), 5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    // Huffman reference: repeatedly join the two smallest nodes; the smaller
    // node's symbols get a 1 prepended on the root side, the other a 0.
    task automatic huff(input logic [47:0] cin, output logic [29:0] code,
                        output logic [17:0] len, output logic [14:0] root);
        int val [6]; int msk [6]; bit alive [6]; int c [6]; int l [6];
        int a, b;
        for (int k = 0; k < 6; k++) begin
            val[k] = int'(cin[8*k +: 8]); msk[k] = 1 << k; alive[k] = 1;
            c[k] = 0; l[k] = 0;
        end
        b = 0;
        repeat (5) begin
            a = -1; b = -1;
            for (int k = 0; k < 6; k++)
                if (alive[k] && (a < 0 || (val[k]*128 + msk[k]) < (val[a]*128 + msk[a]))) a = k;
            for (int k = 0; k < 6; k++)
                if (alive[k] && k != a && (b < 0 || (val[k]*128 + msk[k]) < (val[b]*128 + msk[b]))) b = k;
            for (int k = 0; k < 6; k++) begin
                if (msk[a][k]) begin c[k] |= (1 << l[k]); l[k]++; end
                if (msk[b][k]) l[k]++;
            end
            val[b] = (val[a] + val[b]) & 255;
            msk[b] = msk[b] | msk[a];
            alive[a] = 0;
        end
        code = '0; len = '0;
        for (int k = 0; k < 6; k++) begin
            code[5*k +: 5] = 5'(c[k]);
            len[3*k +: 3]  = 3'(l[k]);
        end
        root = {8'(val[b]), 1'b0, 6'(msk[b])};
    endtask

    // ---------------- cycle model ----------------
    // phase: 0 idle, 1..5 merging, 6 done (edges since accepted start)
    int          phase = 0;
    bit          fresh = 1;
    logic [29:0] exp_code = '0;
    logic [17:0] exp_len  = '0;
    logic [14:0] exp_root = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = 0; fresh = 1; exp_code = '0; exp_len = '0;
        end else if (phase == 0) begin
            if (start) begin
                phase = 1; fresh = 0;
                huff(cnt_in, exp_code, exp_len, exp_root);
            end
        end else if (phase == 6) begin
            phase = 0;
        end else begin
            phase++;
        end
    end

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(phase != 0));
        chk("done", 64'(done), 64'(phase == 6));
        if (phase == 0 || phase == 6) begin
            chk("code_flat", 64'(code_flat), 64'(exp_code));
            chk("len_flat", 64'(len_flat), 64'(exp_len));
        end
        if (phase == 6) begin
            chk("root_e5", 64'(pe_cnt5), 64'(exp_root));
            chk("e6_empty", 64'(pe_cnt6), 64'h7FFF);
        end
        if (phase == 0 && fresh)
            chk("reset_entries", {pe_cnt1, pe_cnt2, pe_cnt3, pe_cnt4},
                {4{15'h7FFF}});
    end

    // ---------------- directed stimulus ----------------
    task automatic run(input logic [47:0] c, output int lat);
        @(posedge clk); #1; start = 1; cnt_in = c;
        @(posedge clk); #1; start = 0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin lat = i; break; end
        end
        if (lat == 0) begin
            errors++; checks++;
            $display("FAIL done_timeout: no done within 20 cycles");
        end
    endtask

    logic [47:0] skew, eq10, ones, zer;
    int lat, npulse, p1, p2, ksum;

    initial begin
        skew = pk_cnt(40, 30, 10, 10, 6, 4);
        eq10 = pk_cnt(10, 10, 10, 10, 10, 10);
        ones = pk_cnt(1, 1, 1, 1, 1, 1);
        zer  = pk_cnt(0, 0, 0, 0, 0, 50);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_e5", 64'(pe_cnt5), 64'h7FFF);
        rst_n = 1;
        repeat (2) @(posedge clk);

        // Skewed counts
        run(skew, lat);
        chk("skew_latency", 64'(lat), 6);
        chk("skew_len", 64'(len_flat), 64'(pk_len(1, 2, 4, 4, 4, 4)));
        chk("skew_code", 64'(code_flat), 64'(pk_code(1, 1, 1, 0, 2, 3)));
        chk("skew_root", 64'(pe_cnt5), 64'({8'd100, 1'b0, 6'h3F}));

        // Back-to-back, all ones: no residue from the skewed run
        run(ones, lat);
        chk("ones_len", 64'(len_flat), 64'(pk_len(3, 3, 3, 3, 2, 2)));
        chk("ones_code", 64'(code_flat), 64'(pk_code(3, 2, 1, 0, 3, 2)));

        // Equal counts, tie-break on mask
        run(eq10, lat);
        chk("eq_latency", 64'(lat), 6);
        chk("eq_len", 64'(len_flat), 64'(pk_len(3, 3, 3, 3, 2, 2)));
        chk("eq_code", 64'(code_flat), 64'(pk_code(3, 2, 1, 0, 3, 2)));

        // Zero counts
        run(zer, lat);
        chk("zero_latency", 64'(lat), 6);
        chk("zero_len", 64'(len_flat), 64'(pk_len(5, 5, 4, 3, 2, 1)));
        chk("zero_code", 64'(code_flat), 64'(pk_code(31, 30, 14, 6, 2, 0)));
        ksum = 0;
        for (int k = 0; k < 6; k++) ksum += 1 << (5 - int'(len_flat[3*k +: 3]));
        chk("zero_kraft", 64'(ksum), 32);

        // start held high for 8 edges
        @(posedge clk); #1; start = 1; cnt_in = skew;
        @(posedge clk);
        npulse = 0; p1 = 0; p2 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                npulse++;
                if (npulse == 1) p1 = i; else if (npulse == 2) p2 = i;
            end
            @(posedge clk); #1;
            if (i == 7) start = 0;
        end
        chk("held_pulses", 64'(npulse), 2);
        chk("held_first", 64'(p1), 6);
        chk("held_second", 64'(p2), 13);
        chk("held_len", 64'(len_flat), 64'(pk_len(1, 2, 4, 4, 4, 4)));
        chk("held_code", 64'(code_flat), 64'(pk_code(1, 1, 1, 0, 2, 3)));

        // Reset during the third merge cycle
        @(posedge clk); #1; start = 1; cnt_in = skew;
        @(posedge clk); #1; start = 0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_entries", {pe_cnt1, pe_cnt2, pe_cnt3, pe_cnt4},
            {4{15'h7FFF}});
        chk("midrst_e56", 64'({pe_cnt5, pe_cnt6}), 64'({15'h7FFF, 15'h7FFF}));
        chk("midrst_code", 64'(code_flat), 0);
        chk("midrst_len", 64'(len_flat), 0);
        npulse = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) npulse++;
        end
        chk("midrst_no_done", 64'(npulse), 0);
        @(posedge clk); #1; rst_n = 1;
        run(eq10, lat);
        chk("postrst_latency", 64'(lat), 6);
        chk("postrst_len", 64'(len_flat), 64'(pk_len(3, 3, 3, 3, 2, 2)));
        chk("postrst_code", 64'(code_flat), 64'(pk_code(3, 2, 1, 0, 3, 2)));

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/huffman_merge_ctrl.md
Name: huffman_merge_ctrl

Overview:
- Sequencing/state stage wrapped around the six-entry sort-and-merge processing element of the Huffman code builder.
- Holds the six 15-bit CNT entry registers, drives them to the PE, and writes back the PE's sorted and merged result each cycle.
- Runs exactly five merge iterations.
- Builds each symbol's codeword and code length from the merge flags, then pulses done.

Parameters:
- NSYM, 6, number of symbols/entries; fixed at 6 and not generalized.
- CLEN_W, 5, codeword register width per symbol; equals the maximum code length, NSYM-1.
- LEN_W, 3, code length field width per symbol.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to build codes from cnt_in; sampled only in IDLE.
- cnt_in  in  48  symbol counts, 8 bits each; symbol k (k=1..6) at bits [8k-1:8k-8].
- busy  out  1  high in MERGE and DONE.
- done  out  1  one-cycle pulse; code_flat/len_flat are valid from this cycle until the next accepted start.
- code_flat  out  30  codeword of symbol k at [5k-1:5k-5]; bit 0 = leaf-most bit.
- len_flat  out  18  code length of symbol k at [3k-1:3k-3].
- pe_cnt1..pe_cnt6  out  15 each  entry registers E1..E6 driven to the PE.
- pe_cnt1_n..pe_cnt6_n  in  15 each  PE sorted outputs; 1..4 survivors, 5 = second smallest, 6 = smallest.
- pe_sum  in  8  PE merged count.
- pe_flag  in  7  PE merged flag; bit 6 is always 0.

Behaviour:
- Entry format: [14:7] count, [6] empty marker, [5:0] one-hot/OR symbol mask; symbol k owns bit k-1.
- EMPTY constant = 15'h7FFF, which sorts above any valid entry.
- Comparisons are over all 15 bits, so equal counts tie-break on the mask value.
- Reset (async, rst_n=0): state IDLE; E1..E6 = EMPTY; merge counter = 0; code_flat = 0; len_flat = 0; busy = 0; done = 0.
- IDLE: busy = 0.
  - On start=1 at a rising edge: load Ek = {cnt_in symbol k, 1'b0, 6'b1<<(k-1)}; clear all codes and lengths; counter = 0; go to MERGE.
  - start=0: stay in IDLE; registers hold.
- MERGE: one merge per cycle, 5 cycles total (counter 0..4). At each edge:
  - E1..E4 <= pe_cnt1_n..pe_cnt4_n.
  - E5 <= {pe_sum, pe_flag}.
  - E6 <= EMPTY.
  - For each symbol k with pe_cnt6_n[k-1]=1: code[k][len[k]] <= 1; len[k] <= len[k]+1.
  - For each symbol k with pe_cnt5_n[k-1]=1: code[k][len[k]] <= 0; len[k] <= len[k]+1.
  - A symbol never appears in both masks.
  - counter==4: go to DONE; otherwise counter+1.
- DONE: done = 1 and busy = 1 for exactly one cycle; then IDLE.
- Latency: start accepted at edge t → merges at edges t+1..t+5 → done high during the cycle after edge t+5.
- After the run, the root entry sits in E5 with count = total and mask 6'h3F.
- start while busy: ignored, with no effect on state or results.
- start in the same cycle as done: ignored, because the FSM is in DONE, not IDLE. It is accepted the next cycle if still high.
- Width rules:
  - Merged count is 8-bit unsigned with no saturation.
  - Precondition: total of the six counts ≤ 254; results are undefined above that and are not checked.
  - Zero counts are legal and are treated as ordinary entries.
- Reset asserted mid-MERGE: everything returns to reset values immediately; no done pulse; a fresh start is required.
- Codeword reading: the len[k] low bits of code[k], MSB first, give the root-to-leaf code.

Test Plan:
- Skewed counts:
  - Stimulus: start with counts 40,30,10,10,6,4 (symbols 1..6).
  - Required: done exactly 6 cycles after the start edge.
  - Required: len = 1,2,4,4,4,4; code = 1,1,1,0,2,3.
  - Required: final E5 = {8'd100, 1'b0, 6'h3F}.
- Equal counts (tie-break):
  - Stimulus: all counts 10.
  - Required: len = 3,3,3,3,2,2; code = 3,2,1,0,3,2.
- start held high during busy:
  - Stimulus: start high for 8 cycles with counts 40,30,10,10,6,4.
  - Required: first run as in the skewed test; exactly one done pulse; then a second run begins the cycle after done.
  - Required: second done gives identical results.
- Reset mid-run:
  - Stimulus: rst_n low at the 3rd MERGE cycle.
  - Required: immediately E1..E6 = 7FFF, busy = 0, code_flat = 0, len_flat = 0; no done pulse.
  - Required: a following start with the equal-counts vector gives the equal-counts results.
- Back-to-back runs clear old results:
  - Stimulus: the skewed run, then counts 1,1,1,1,1,1.
  - Required: second result len = 3,3,3,3,2,2, code = 3,2,1,0,3,2, with no residue from run 1.
- Zero counts:
  - Stimulus: counts 0,0,0,0,0,50.
  - Required: done after 6 cycles; len = 5,5,4,3,2,1; sum of 2^-len over all symbols = 1.
